// File: rtl/alu_pkg.sv
// Opcode constants and sequencer state encoding shared by the ALU sequencer slice.
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;
  localparam logic [4:0] OP_INV = 5'd5;
  localparam logic [4:0] OP_INC = 5'd6;
  localparam logic [4:0] OP_DEC = 5'd7;
  localparam logic [4:0] OP_MAX = 5'd7;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } seq_state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle between the two requesters and the ALU sequencer.
interface alu_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 5
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*SEL_W-1:0] req_op;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [1:0]         req_chain;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [WIDTH-1:0]   rsp_data;
  logic               rsp_carry;
  logic               rsp_zero;
  logic               rsp_error;

  modport master (
    output req_valid, req_op, req_a, req_b, req_chain, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero, rsp_error
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_chain, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero, rsp_error
  );
endinterface

// File: rtl/alu_sequencer_arbiter.sv
// Two-input round-robin arbiter; after each accept the other requester gets priority.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] req_valid,
  output logic [1:0] grant
);

  logic ptr_reg;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr_reg ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // grant is only non-zero for a valid requester, so any grant is an accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= 1'b0;
    end else if (grant != 2'b00) begin
      ptr_reg <= grant[0];
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Shares one combinational 16-bit ALU between two requesters: arbitrate, issue,
// capture on the enabled bus, return a tagged response, and keep per-requester carry.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEL_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_sequencer_if.slave   bus,
  output logic [1:0]       carry_flag,
  output logic [WIDTH-1:0] alu_in_1,
  output logic [WIDTH-1:0] alu_in_2,
  output logic [SEL_W-1:0] alu_select,
  output logic             alu_carry_in,
  output logic             alu_enable,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             alu_carry_out,
  input  logic             alu_zero_flag
);

  seq_state_e       state_reg;
  logic [1:0]       grant;
  logic             sel_id;
  logic             id_reg;
  logic [SEL_W-1:0] op_reg;
  logic [SEL_W-1:0] op_arr [2];
  logic [WIDTH-1:0] a_arr  [2];
  logic [WIDTH-1:0] b_arr  [2];

  logic             rsp_valid_reg, rsp_id_reg, rsp_carry_reg, rsp_zero_reg, rsp_error_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic [1:0]       carry_flag_reg;
  logic [WIDTH-1:0] alu_in_1_reg, alu_in_2_reg;
  logic [SEL_W-1:0] alu_select_reg;
  logic             alu_carry_in_reg, alu_enable_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign op_arr[gi] = bus.req_op[gi*SEL_W +: SEL_W];
      assign a_arr[gi]  = bus.req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi]  = bus.req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Gating with rst_n keeps req_ready low for the whole reset, not just after the first edge
  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (rst_n && (state_reg == IDLE)),
    .req_valid (bus.req_valid),
    .grant     (grant)
  );

  assign sel_id = grant[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      id_reg           <= 1'b0;
      op_reg           <= '0;
      rsp_valid_reg    <= 1'b0;
      rsp_id_reg       <= 1'b0;
      rsp_data_reg     <= '0;
      rsp_carry_reg    <= 1'b0;
      rsp_zero_reg     <= 1'b0;
      rsp_error_reg    <= 1'b0;
      carry_flag_reg   <= 2'b00;
      alu_in_1_reg     <= '0;
      alu_in_2_reg     <= '0;
      alu_select_reg   <= '0;
      alu_carry_in_reg <= 1'b0;
      alu_enable_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant != 2'b00) begin
            id_reg    <= sel_id;
            op_reg    <= op_arr[sel_id];
            state_reg <= ISSUE;
            // Invalid opcodes leave the ALU lines at zero and just spend the ISSUE slot
            if (op_arr[sel_id] <= SEL_W'(OP_MAX)) begin
              alu_in_1_reg     <= a_arr[sel_id];
              alu_in_2_reg     <= b_arr[sel_id];
              alu_select_reg   <= op_arr[sel_id];
              alu_carry_in_reg <= (op_arr[sel_id] == SEL_W'(OP_ADD)) &&
                                  bus.req_chain[sel_id] && carry_flag_reg[sel_id];
            end
          end
        end
        ISSUE: begin
          if (op_reg > SEL_W'(OP_MAX)) begin
            rsp_valid_reg <= 1'b1;
            rsp_id_reg    <= id_reg;
            rsp_data_reg  <= '0;
            rsp_carry_reg <= 1'b0;
            rsp_zero_reg  <= 1'b0;
            rsp_error_reg <= 1'b1;
            state_reg     <= RESP;
          end else begin
            alu_enable_reg <= 1'b1;
            state_reg      <= CAPTURE;
          end
        end
        CAPTURE: begin
          rsp_valid_reg          <= 1'b1;
          rsp_id_reg             <= id_reg;
          rsp_data_reg           <= alu_data;
          rsp_carry_reg          <= alu_carry_out;
          rsp_zero_reg           <= alu_zero_flag;
          rsp_error_reg          <= 1'b0;
          carry_flag_reg[id_reg] <= alu_carry_out;
          alu_in_1_reg           <= '0;
          alu_in_2_reg           <= '0;
          alu_select_reg         <= '0;
          alu_carry_in_reg       <= 1'b0;
          alu_enable_reg         <= 1'b0;
          state_reg              <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_carry = rsp_carry_reg;
  assign bus.rsp_zero  = rsp_zero_reg;
  assign bus.rsp_error = rsp_error_reg;
  assign carry_flag    = carry_flag_reg;
  assign alu_in_1      = alu_in_1_reg;
  assign alu_in_2      = alu_in_2_reg;
  assign alu_select    = alu_select_reg;
  assign alu_carry_in  = alu_carry_in_reg;
  assign alu_enable    = alu_enable_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU on the bus, queue-free arithmetic reference
// model for arbitration order, carry chaining and responses.
module tb_alu_sequencer;

  localparam int WIDTH = 16;
  localparam int SEL_W = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  carry_flag;
  logic [15:0] alu_in_1, alu_in_2, alu_data;
  logic [4:0]  alu_select;
  logic        alu_carry_in, alu_enable, alu_carry_out, alu_zero_flag;
  logic [17:0] alu_res;

  int total = 0;
  int bad = 0;
  int model_ptr = 0;
  logic model_carry [2];

  logic [15:0] obs_data;
  logic        obs_carry, obs_zero, obs_error, obs_id;

  alu_sequencer_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

  alu_sequencer #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .carry_flag    (carry_flag),
    .alu_in_1      (alu_in_1),
    .alu_in_2      (alu_in_2),
    .alu_select    (alu_select),
    .alu_carry_in  (alu_carry_in),
    .alu_enable    (alu_enable),
    .alu_data      (alu_data),
    .alu_carry_out (alu_carry_out),
    .alu_zero_flag (alu_zero_flag)
  );

  always #5 clk = ~clk;

  // Returns {carry, zero, data}; subtract/decrement report borrow as carry
  function automatic logic [17:0] alu_ref(input logic [4:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin);
    int unsigned x, y, s;
    logic [15:0] d;
    logic c;
    x = a; y = b; c = 1'b0; d = 16'h0;
    case (op)
      5'd0: begin s = x + y + (cin ? 1 : 0); d = 16'(s % 65536); c = (s >= 65536); end
      5'd1: begin
        if (x >= y) d = 16'(x - y);
        else begin d = 16'(x + 65536 - y); c = 1'b1; end
      end
      5'd2: d = a & b;
      5'd3: d = a | b;
      5'd4: d = a ^ b;
      5'd5: d = ~a;
      5'd6: begin d = 16'((x + 1) % 65536); c = (x == 65535); end
      5'd7: begin d = (x == 0) ? 16'hFFFF : 16'(x - 1); c = (x == 0); end
      default: d = 16'h0;
    endcase
    return {c, (d == 16'h0), d};
  endfunction

  // The ALU only drives its bus while enabled
  always_comb begin
    alu_res       = alu_ref(alu_select, alu_in_1, alu_in_2, alu_carry_in);
    alu_data      = alu_enable ? alu_res[15:0] : 16'h0;
    alu_carry_out = alu_enable & alu_res[17];
    alu_zero_flag = alu_enable & alu_res[16];
  end

  function automatic int model_winner(input logic [1:0] v);
    if (v == 2'b11) return model_ptr;
    return v[1] ? 1 : 0;
  endfunction

  task automatic model_step(input int id, input logic [4:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic chain, output logic [15:0] ed,
                            output logic ec, output logic ez, output logic ee);
    logic [17:0] r;
    model_ptr = 1 - id;
    if (op > 5'd7) begin
      ed = 16'h0; ec = 1'b0; ez = 1'b0; ee = 1'b1;
    end else begin
      r = alu_ref(op, a, b, (op == 5'd0 && chain) ? model_carry[id] : 1'b0);
      ed = r[15:0]; ez = r[16]; ec = r[17]; ee = 1'b0;
      model_carry[id] = ec;
    end
  endtask

  task automatic set_req(input int id, input logic [4:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic chain);
    bus.req_op[id*SEL_W +: SEL_W] = op;
    bus.req_a[id*WIDTH +: WIDTH]  = a;
    bus.req_b[id*WIDTH +: WIDTH]  = b;
    bus.req_chain[id]             = chain;
    bus.req_valid[id]             = 1'b1;
  endtask

  // Waits for an accept, then for the response; consumes it only if rsp_ready is high
  task automatic run_txn(output int who, output int lat, output int en_cycles);
    who = -1; lat = -1; en_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) begin who = bus.req_ready[1] ? 1 : 0; break; end
    end
    if (who < 0) begin
      total++; bad++;
      $display("FAIL accept_timeout req_ready=%b required=nonzero", bus.req_ready);
      return;
    end
    @(posedge clk); #1;
    bus.req_valid[who] = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (alu_enable) en_cycles++;
      if (bus.rsp_valid) begin lat = n - 1; break; end
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL rsp_timeout rsp_valid=%b required=1", bus.rsp_valid);
      return;
    end
    obs_data = bus.rsp_data; obs_carry = bus.rsp_carry; obs_zero = bus.rsp_zero;
    obs_error = bus.rsp_error; obs_id = bus.rsp_id;
    $display("txn who=%0d lat=%0d id=%0d data=%h carry=%b zero=%b error=%b flags=%b",
             who, lat, obs_id, obs_data, obs_carry, obs_zero, obs_error, carry_flag);
    if (bus.rsp_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; #1; rst_n = 1'b0;
    bus.req_valid = 2'b11;
    repeat (2) @(negedge clk);
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b want=00", bus.req_ready); end
    total++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_carry, bus.rsp_zero, bus.rsp_error} !== 5'b0) begin
      bad++; $display("FAIL reset_rsp_bits got=%b want=00000", {bus.rsp_valid, bus.rsp_id, bus.rsp_carry, bus.rsp_zero, bus.rsp_error}); end
    total++; if (bus.rsp_data !== 16'h0) begin bad++; $display("FAIL reset_rsp_data got=%h want=0000", bus.rsp_data); end
    total++; if (carry_flag !== 2'b00) begin bad++; $display("FAIL reset_carry_flag got=%b want=00", carry_flag); end
    total++; if ({alu_in_1, alu_in_2, alu_select, alu_carry_in, alu_enable} !== 39'h0) begin
      bad++; $display("FAIL reset_alu_lines got=%h,%h,%h,%b,%b want=0", alu_in_1, alu_in_2, alu_select, alu_carry_in, alu_enable); end
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
    model_ptr = 0; model_carry[0] = 1'b0; model_carry[1] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_add();
    int who, lat, en; logic [15:0] ed; logic ec, ez, ee;
    set_req(0, 5'd0, 16'h0003, 16'h0004, 1'b0);
    run_txn(who, lat, en);
    model_step(0, 5'd0, 16'h0003, 16'h0004, 1'b0, ed, ec, ez, ee);
    total++; if (who !== 0) begin bad++; $display("FAIL add_grant got=%0d want=0", who); end
    total++; if (lat !== 2) begin bad++; $display("FAIL add_latency got=%0d want=2", lat); end
    total++; if (obs_data !== 16'h0007) begin bad++; $display("FAIL add_data got=%h want=0007", obs_data); end
    total++; if ({obs_id, obs_carry, obs_zero, obs_error} !== 4'b0000) begin
      bad++; $display("FAIL add_flags got=%b want=0000", {obs_id, obs_carry, obs_zero, obs_error}); end
    total++; if (en !== 1) begin bad++; $display("FAIL add_enable_cycles got=%0d want=1", en); end
  endtask

  task automatic test_chain();
    int who, lat, en; logic [15:0] ed; logic ec, ez, ee;
    set_req(1, 5'd0, 16'hFFFF, 16'h0001, 1'b0);
    run_txn(who, lat, en);
    model_step(1, 5'd0, 16'hFFFF, 16'h0001, 1'b0, ed, ec, ez, ee);
    total++; if ({obs_id, obs_data, obs_carry, obs_zero} !== {1'b1, 16'h0000, 1'b1, 1'b1}) begin
      bad++; $display("FAIL chain1_rsp got=id%b/%h/c%b/z%b want=id1/0000/c1/z1", obs_id, obs_data, obs_carry, obs_zero); end
    total++; if (carry_flag !== 2'b10) begin bad++; $display("FAIL chain1_carry_flag got=%b want=10", carry_flag); end
    set_req(1, 5'd0, 16'h0000, 16'h0000, 1'b1);
    run_txn(who, lat, en);
    model_step(1, 5'd0, 16'h0000, 16'h0000, 1'b1, ed, ec, ez, ee);
    total++; if ({obs_data, obs_carry} !== {16'h0001, 1'b0}) begin
      bad++; $display("FAIL chain2_rsp got=%h/c%b want=0001/c0", obs_data, obs_carry); end
    total++; if (carry_flag !== 2'b00) begin bad++; $display("FAIL chain2_carry_flag got=%b want=00", carry_flag); end
  endtask

  task automatic test_fairness();
    int who, lat, en; logic [15:0] ed; logic ec, ez, ee;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 5'd6, 16'h0010, 16'h0000, 1'b0);
      set_req(1, 5'd6, 16'h0010, 16'h0000, 1'b0);
      run_txn(who, lat, en);
      model_step(who, 5'd6, 16'h0010, 16'h0000, 1'b0, ed, ec, ez, ee);
      total++; if (who !== i % 2 || obs_id !== 1'(i % 2)) begin
        bad++; $display("FAIL fair_order txn=%0d got=%0d/id%b want=%0d", i, who, obs_id, i % 2); end
      total++; if (obs_data !== 16'h0011) begin bad++; $display("FAIL fair_data txn=%0d got=%h want=0011", i, obs_data); end
    end
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_invalid();
    int who, lat, en; logic [15:0] ed, a, b; logic ec, ez, ee;
    set_req(0, 5'd0, 16'hFFFF, 16'h0001, 1'b0);
    run_txn(who, lat, en);
    model_step(0, 5'd0, 16'hFFFF, 16'h0001, 1'b0, ed, ec, ez, ee);
    total++; if (carry_flag !== 2'b01) begin bad++; $display("FAIL inv_setup_carry_flag got=%b want=01", carry_flag); end
    a = 16'($urandom); b = 16'($urandom);
    set_req(0, 5'd9, a, b, 1'b1);
    run_txn(who, lat, en);
    model_step(0, 5'd9, a, b, 1'b1, ed, ec, ez, ee);
    total++; if ({obs_error, obs_data, obs_carry, obs_zero} !== {1'b1, 16'h0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL inv_rsp got=e%b/%h/c%b/z%b want=e1/0000/c0/z0", obs_error, obs_data, obs_carry, obs_zero); end
    total++; if (lat !== 1) begin bad++; $display("FAIL inv_latency got=%0d want=1", lat); end
    total++; if (en !== 0) begin bad++; $display("FAIL inv_alu_enable got=%0d want=0", en); end
    total++; if (carry_flag !== 2'b01) begin bad++; $display("FAIL inv_carry_flag got=%b want=01", carry_flag); end
  endtask

  task automatic test_backpressure();
    int who, lat, en; logic [15:0] ed, a, b; logic ec, ez, ee;
    a = 16'($urandom); b = 16'($urandom);
    bus.rsp_ready = 1'b0;
    set_req(1, 5'd3, a, b, 1'b0);
    run_txn(who, lat, en);
    model_step(1, 5'd3, a, b, 1'b0, ed, ec, ez, ee);
    total++; if (obs_data !== ed) begin bad++; $display("FAIL bp_data got=%h want=%h", obs_data, ed); end
    set_req(0, 5'd2, a, b, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_error, bus.rsp_data} !== {1'b1, 1'b1, 1'b0, ed}) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=v%b/id%b/e%b/%h want=v1/id1/e0/%h", i, bus.rsp_valid, bus.rsp_id, bus.rsp_error, bus.rsp_data, ed); end
      total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL bp_req_ready cyc=%0d got=%b want=00", i, bus.req_ready); end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL bp_resume got=%b want=01", bus.req_ready); end
    run_txn(who, lat, en);
    model_step(0, 5'd2, a, b, 1'b0, ed, ec, ez, ee);
    total++; if (who !== 0 || obs_data !== (a & b)) begin
      bad++; $display("FAIL bp_next got=%0d/%h want=0/%h", who, obs_data, a & b); end
  endtask

  task automatic test_reset_mid_op();
    int who, lat, en, seen; logic [15:0] ed; logic ec, ez, ee;
    set_req(0, 5'd0, 16'h1234, 16'h1111, 1'b0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) begin seen = 1; break; end
    end
    total++; if (seen !== 1) begin bad++; $display("FAIL mid_accept got=%b want=nonzero", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    total++; if (alu_enable !== 1'b1) begin bad++; $display("FAIL mid_in_capture alu_enable got=%b want=1", alu_enable); end
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    total++; if ({bus.rsp_valid, bus.req_ready, alu_enable, alu_carry_in} !== 5'b0) begin
      bad++; $display("FAIL mid_reset_ctrl got=%b want=00000", {bus.rsp_valid, bus.req_ready, alu_enable, alu_carry_in}); end
    total++; if ({alu_in_1, alu_in_2, alu_select, bus.rsp_data} !== 53'h0) begin
      bad++; $display("FAIL mid_reset_data got=%h,%h,%h,%h want=0", alu_in_1, alu_in_2, alu_select, bus.rsp_data); end
    total++; if (carry_flag !== 2'b00) begin bad++; $display("FAIL mid_reset_carry_flag got=%b want=00", carry_flag); end
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0; model_carry[0] = 1'b0; model_carry[1] = 1'b0;
    seen = 0;
    repeat (3) begin @(negedge clk); if (bus.rsp_valid) seen = 1; end
    total++; if (seen !== 0) begin bad++; $display("FAIL mid_no_response got=%0d want=0", seen); end
    @(posedge clk); #1;
    set_req(1, 5'd1, 16'h0005, 16'h0003, 1'b0);
    run_txn(who, lat, en);
    model_step(1, 5'd1, 16'h0005, 16'h0003, 1'b0, ed, ec, ez, ee);
    total++; if ({who[0], obs_data, obs_carry, obs_error} !== {1'b1, 16'h0002, 1'b0, 1'b0}) begin
      bad++; $display("FAIL mid_after_rsp got=%0d/%h/c%b/e%b want=1/0002/c0/e0", who, obs_data, obs_carry, obs_error); end
  endtask

  task automatic test_random();
    int who, lat, en, win; logic [15:0] ed; logic ec, ez, ee;
    logic [1:0]  mask;
    logic [4:0]  r_op [2];
    logic [15:0] r_a [2], r_b [2];
    logic        r_ch [2];
    for (int t = 0; t < 24; t++) begin
      mask = 2'($urandom_range(1, 3));
      bus.req_valid = 2'b00;
      for (int k = 0; k < 2; k++) begin
        r_op[k] = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(8, 31));
        r_a[k]  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        r_b[k]  = 16'($urandom);
        r_ch[k] = 1'($urandom_range(0, 1));
        if (mask[k]) set_req(k, r_op[k], r_a[k], r_b[k], r_ch[k]);
      end
      win = model_winner(mask);
      run_txn(who, lat, en);
      model_step(win, r_op[win], r_a[win], r_b[win], r_ch[win], ed, ec, ez, ee);
      total++; if (who !== win || obs_id !== 1'(win)) begin
        bad++; $display("FAIL rnd_grant t=%0d got=%0d/id%b want=%0d", t, who, obs_id, win); end
      total++; if ({obs_data, obs_carry, obs_zero, obs_error} !== {ed, ec, ez, ee}) begin
        bad++; $display("FAIL rnd_rsp t=%0d got=%h/c%b/z%b/e%b want=%h/c%b/z%b/e%b", t, obs_data, obs_carry, obs_zero, obs_error, ed, ec, ez, ee); end
      total++; if (lat !== (ee ? 1 : 2) || en !== (ee ? 0 : 1)) begin
        bad++; $display("FAIL rnd_timing t=%0d got=lat%0d/en%0d want=lat%0d/en%0d", t, lat, en, ee ? 1 : 2, ee ? 0 : 1); end
      total++; if (carry_flag !== {model_carry[1], model_carry[0]}) begin
        bad++; $display("FAIL rnd_carry_flag t=%0d got=%b want=%b", t, carry_flag, {model_carry[1], model_carry[0]}); end
      total++; if ({alu_in_1, alu_in_2, alu_select, alu_carry_in, alu_enable} !== 39'h0) begin
        bad++; $display("FAIL rnd_alu_idle t=%0d got=%h,%h,%h,%b,%b want=0", t, alu_in_1, alu_in_2, alu_select, alu_carry_in, alu_enable); end
    end
    bus.req_valid = 2'b00;
  endtask

  initial begin
    bus.req_valid = 2'b00; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.req_chain = 2'b00; bus.rsp_ready = 1'b1;
    model_carry[0] = 1'b0; model_carry[1] = 1'b0;
    test_reset();
    test_single_add();
    test_chain();
    test_fairness();
    test_invalid();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Sequencer and round-robin arbiter that shares the single 16-bit ALU between two requesters.
- Accepts operation requests on a valid/ready handshake and grants one request at a time.
- Drives the ALU operand, select, carry and bus-enable lines, captures the result and flags, and returns a tagged response.
- Keeps a per-requester carry flag so multi-word add chains from different requesters do not corrupt each other.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must match the ALU.
- SEL_W, 5, ALU select width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  request valid, bit i = requester i.
- req_ready  out  2  request accepted this cycle (one-hot or zero).
- req_op  in  2*SEL_W  opcode, requester i at [i*SEL_W +: SEL_W].
- req_a  in  2*WIDTH  first operand per requester.
- req_b  in  2*WIDTH  second operand per requester.
- req_chain  in  2  for op 0, use the stored carry as carry_in.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  WIDTH  result.
- rsp_carry  out  1  carry captured for this op.
- rsp_zero  out  1  zero flag captured for this op.
- rsp_error  out  1  opcode was invalid (8..31).
- carry_flag  out  2  stored carry per requester.
- alu_in_1, alu_in_2  out  WIDTH  ALU operands.
- alu_select  out  SEL_W  ALU opcode.
- alu_carry_in  out  1  ALU carry in.
- alu_enable  out  1  ALU bus drive enable.
- alu_data  in  WIDTH  ALU bus value.
- alu_carry_out, alu_zero_flag  in  1  ALU flags.

## Operation
- States: IDLE, ISSUE, CAPTURE, RESP.
- **IDLE:**
  - The arbiter grants one valid requester; req_ready = grant, combinational from req_valid and the priority pointer.
  - Priority pointer starts at requester 0.
  - After every accept, the pointer moves to the other requester.
  - If only one requester is valid, it is granted regardless of the pointer.
- **Accept:**
  - Latch id, op, a, b and chain.
  - Op ≤ 7: go to ISSUE.
  - Op 8..31: go to RESP with rsp_error=1, rsp_data=0, rsp_carry=0, rsp_zero=0. The ALU is not touched and carry_flag is unchanged.
- **ISSUE:**
  - Drive alu_in_1=a, alu_in_2=b, alu_select=op.
  - alu_carry_in = (op==0 && chain) ? carry_flag[id] : 0.
  - alu_enable=0.
- **CAPTURE:**
  - Same ALU drive as ISSUE, with alu_enable=1.
  - At the clock edge, latch alu_data, alu_carry_out and alu_zero_flag into the response registers, and write alu_carry_out into carry_flag[id] (all ops).
- **RESP:**
  - rsp_valid=1 with stable fields until rsp_valid && rsp_ready.
  - Then return to IDLE.
- Outside ISSUE/CAPTURE: ALU outputs are 0 and alu_enable=0.

## Timing
- Reset values:
  - State IDLE; pointer 0.
  - req_ready=0 while rst_n is low.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_carry=0, rsp_zero=0, rsp_error=0.
  - carry_flag=0; all ALU outputs 0, alu_enable=0.
- Valid op latency: accept at edge T; ISSUE for cycle T..T+1; CAPTURE for T+1..T+2; rsp_valid high after edge T+2.
- Invalid op latency: rsp_valid high after edge T+1.
- Throughput: one op per 4 cycles at best. req_ready is 0 in every state except IDLE.
- Response holding: rsp_ready low holds RESP indefinitely, with all rsp_* stable.
- Requester 0 and requester 1 both valid in IDLE: the pointer selects the winner. The loser stays pending and is not dropped.
- A requester dropping req_valid before it is granted: legal, nothing latched.
- Reset mid-operation: rst_n low in any state returns to IDLE asynchronously. Any in-flight response is discarded and carry_flag is cleared.
- ALU is combinational; alu_enable is asserted one full cycle after the operands, so the bus is stable before capture.

## Structure
- Shared package alu_pkg holds:
  - Opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_INV=5, OP_INC=6, OP_DEC=7, OP_MAX=7.
  - The state enumeration.
- One sub-module, rr_arbiter2:
  - Two-input round-robin grant with a pointer register.
  - The pointer advances on accept (grant && req_valid).
  - Instantiated once.
- Top level contains the FSM, request latch, response registers and carry_flag registers. It connects to the ALU unchanged.

## Test plan
- **Single add:** requester 0 sends op 0, a=0x0003, b=0x0004, chain=0 → rsp after 2 cycles: data 0x0007, carry 0, zero 0, id 0, error 0.
- **Chained 32-bit add:**
  - Step 1: requester 1 sends op 0, 0xFFFF+0x0001 → data 0x0000, carry 1, zero 1, carry_flag[1]=1.
  - Step 2: requester 1 sends op 0, 0x0000+0x0000 with chain=1 → data 0x0001, carry 0.
  - carry_flag[0] stays 0 throughout.
- **Fairness:** both requesters hold req_valid with op 6 (a=0x0010) for 4 transactions → grant order 0,1,0,1; each data 0x0011.
- **Invalid op:** op 9 → rsp_error=1, data 0 one cycle after accept; alu_enable never high; carry_flag unchanged.
- **Backpressure:** rsp_ready low for 5 cycles → rsp fields stable, req_ready stays 0; accept resumes the cycle after the handshake.
- **Reset mid-op:** rst_n pulsed low during CAPTURE → all outputs at reset values, no response emitted, the next request completes normally.
